// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue: fetch FSM
// states, the {pc, instr} queue entry and the PC step helper.
package ifetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus bundle between the prefetch queue, the instruction memory and the IF stage.
// slave = the queue side, master = memory + pipeline side.
interface ifetch_queue_if;

  // Fetch port: imem_req is a valid that, once raised, holds together with a
  // stable imem_addr until the cycle imem_ack=1 (ack may come in the first
  // cycle); that ack cycle completes the transfer and carries imem_rdata.
  // IF port: if_valid marks the head; if_take consumes it in that cycle.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_take;

  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr, if_pc, if_pc4,
    input  if_take, redirect, redirect_pc
  );

  modport master (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr, if_pc, if_pc4,
    output if_take, redirect, redirect_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {pc, instr} entries with flush; head is read
// combinationally. DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  ifq_entry_t                 push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output ifq_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  ifq_entry_t    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetch FSM, fetch PC, redirect handling.
// Define IFETCH_QUEUE_BYPASS_EN to forward an ack straight to the IF port when empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  ifetch_queue_if.slave              bus,
  output fetch_state_e               dbg_state_o,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   stale_addr_q, stale_addr_d;

  ifq_entry_t    head;
  ifq_entry_t    push_data;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          live_ack;
  logic          bypass_hit;
  logic          push;
  logic          pop;
  logic [31:0]   out_pc;

  assign empty    = (count == '0);
  // An ack only counts as data when it answers a live (non-stale) request.
  assign live_ack = (state_q == BUSY) && bus.imem_ack && !bus.redirect;

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && live_ack;
`else
  assign bypass_hit = 1'b0;
`endif

  assign push      = live_ack && !(bypass_hit && bus.if_take);
  assign pop       = bus.if_take && !empty && !bus.redirect;
  assign push_data = '{pc: fetch_pc_q, instr: bus.imem_rdata};

  always_comb begin
    count_next = count;
    if (bus.redirect) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (bus.redirect),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    stale_addr_d = stale_addr_q;
    case (state_q)
      IDLE: begin
        state_d = (count_next < DEPTH_C) ? BUSY : IDLE;
      end
      BUSY: begin
        if (bus.redirect) begin
          // Without an ack the request stays outstanding at its old address.
          state_d      = bus.imem_ack ? BUSY : DROP;
          stale_addr_d = fetch_pc_q;
        end else if (bus.imem_ack) begin
          state_d = (count_next < DEPTH_C) ? BUSY : IDLE;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_d = BUSY;
      end
      default: state_d = BUSY;
    endcase
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (live_ack) begin
      fetch_pc_d = next_pc(fetch_pc_q);
    end
  end

  // BUSY out of reset so the first request goes out as soon as reset drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BUSY;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      stale_addr_q <= stale_addr_d;
    end
  end

  assign bus.imem_req  = !reset && (state_q != IDLE);
  assign bus.imem_addr = (state_q == DROP) ? stale_addr_q : fetch_pc_q;

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_instr = NOP_INSTR;
    out_pc       = 32'h0;
    if (!empty) begin
      bus.if_valid = 1'b1;
      bus.if_instr = head.instr;
      out_pc       = head.pc;
    end else if (bypass_hit) begin
      bus.if_valid = 1'b1;
      bus.if_instr = bus.imem_rdata;
      out_pc       = fetch_pc_q;
    end
  end

  assign bus.if_pc  = out_pc;
  assign bus.if_pc4 = next_pc(out_pc);

  assign dbg_state_o = state_q;
  assign dbg_count_o = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count == DEPTH_C));

  a_req_hold: assert property (@(posedge clk) disable iff (reset)
    (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && $stable(bus.imem_addr)));

endmodule
